operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/op_fetch_pkg.sv | 20 ++
 rtl/operand_sel.sv | 28 ++
 rtl/operand_fetch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/op_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : op_fetch_pkg
// Brief    : Shared widths and occupancy state encoding for operand fetch.
// Revision : 1.0
// ============================================================================
package op_fetch_pkg;

    localparam int N    = 32;
    localparam int NREG = 16;
    localparam int IDXW = 4;

    typedef logic [1:0] occ_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/operand_sel.sv
`default_nettype none
// ============================================================================
// Module   : operand_sel
// Brief    : Register read mux with write-back bypass on a clean one-hot hit.
// Revision : 1.0
// ============================================================================
module operand_sel #(
    parameter int N    = op_fetch_pkg::N,
    parameter int NREG = op_fetch_pkg::NREG
) (
    input  logic [op_fetch_pkg::IDXW-1:0] idx,
    input  logic [NREG*N-1:0]             rf_q,
    input  logic                          wb_valid,
    input  logic [NREG-1:0]               wb_sel,
    input  logic [N-1:0]                  wb_data,
    output logic [N-1:0]                  operand
);

    logic onehot;
    logic hit;

    // Zero or multi-bit selects are treated as no write for bypass purposes.
    assign onehot  = (wb_sel != '0) && ((wb_sel & (wb_sel - NREG'(1))) == '0);
    assign hit     = wb_valid && onehot && wb_sel[idx];
    assign operand = hit ? wb_data : rf_q[int'(idx)*N +: N];

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Brief    : Captures two source operands per request into a 2-entry FIFO.
// Revision : 1.0
// ============================================================================
module operand_fetch #(
    parameter int N    = op_fetch_pkg::N,
    parameter int NREG = op_fetch_pkg::NREG
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [op_fetch_pkg::IDXW-1:0] req_ra,
    input  logic [op_fetch_pkg::IDXW-1:0] req_rb,
    input  logic [NREG*N-1:0]             rf_q,
    input  logic                          wb_valid,
    input  logic [NREG-1:0]               wb_sel,
    input  logic [N-1:0]                  wb_data,
    output logic                          op_valid,
    input  logic                          op_ready,
    output logic [N-1:0]                  op_a,
    output logic [N-1:0]                  op_b
);

    op_fetch_pkg::occ_t state_q, state_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [N-1:0]       mem_a_q [2];
    logic [N-1:0]       mem_a_d [2];
    logic [N-1:0]       mem_b_q [2];
    logic [N-1:0]       mem_b_d [2];
    logic [N-1:0]       op_a_q, op_a_d;
    logic [N-1:0]       op_b_q, op_b_d;
    logic [N-1:0]       sel_a, sel_b;
    logic               push, pop;

    operand_sel #(.N(N), .NREG(NREG)) u_sel_a (
        .idx      (req_ra),
        .rf_q     (rf_q),
        .wb_valid (wb_valid),
        .wb_sel   (wb_sel),
        .wb_data  (wb_data),
        .operand  (sel_a)
    );

    operand_sel #(.N(N), .NREG(NREG)) u_sel_b (
        .idx      (req_rb),
        .rf_q     (rf_q),
        .wb_valid (wb_valid),
        .wb_sel   (wb_sel),
        .wb_data  (wb_data),
        .operand  (sel_b)
    );

    // Gated by rst_n so nothing is accepted while the FIFO is held in reset.
    assign req_ready = rst_n && (state_q != op_fetch_pkg::ST_FULL);
    assign op_valid  = (state_q != op_fetch_pkg::ST_EMPTY);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign push      = req_valid && req_ready;
    assign pop       = op_valid && op_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_a_d  = mem_a_q;
        mem_b_d  = mem_b_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;

        if (push) begin
            mem_a_d[wr_ptr_q] = sel_a;
            mem_b_d[wr_ptr_q] = sel_b;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            op_fetch_pkg::ST_EMPTY: if (push) state_d = op_fetch_pkg::ST_ONE;
            op_fetch_pkg::ST_ONE: begin
                if (push && !pop)      state_d = op_fetch_pkg::ST_FULL;
                else if (pop && !push) state_d = op_fetch_pkg::ST_EMPTY;
            end
            op_fetch_pkg::ST_FULL:  if (pop) state_d = op_fetch_pkg::ST_ONE;
            default:                state_d = op_fetch_pkg::ST_EMPTY;
        endcase

        // Output registers track the next head; they freeze once the FIFO drains.
        if (state_d != op_fetch_pkg::ST_EMPTY) begin
            op_a_d = mem_a_d[rd_ptr_d];
            op_b_d = mem_b_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= op_fetch_pkg::ST_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_a_q  <= '{default: '0};
            mem_b_q  <= '{default: '0};
            op_a_q   <= '0;
            op_b_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_a_q  <= mem_a_d;
            mem_b_q  <= mem_b_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
        end
    end

endmodule
`default_nettype wire
